// File: rtl/syn_sram_acc_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : syn_sram_acc_arb_if                                              |
// | Brief   : Client-side and SRAM-controller-side bundle of the access arbiter |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface syn_sram_acc_arb_if #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int TAG_DEPTH = 8
);
    localparam int c_cnt_w = $clog2(TAG_DEPTH) + 1;

    logic [NUM_CH-1:0]        cl_rd_en_i;
    logic [NUM_CH-1:0]        cl_wr_en_i;
    logic [NUM_CH*ADDR_W-1:0] cl_addr_i;
    logic [NUM_CH*DATA_W-1:0] cl_wr_data_i;
    logic [NUM_CH-1:0]        cl_rdy_o;
    logic [NUM_CH-1:0]        cl_rd_valid_o;
    logic [DATA_W-1:0]        cl_rd_data_o;
    logic                     sram_rdy_i;
    logic                     sram_rd_valid_i;
    logic [DATA_W-1:0]        sram_rd_data_i;
    logic                     sram_rd_en_o;
    logic                     sram_wr_en_o;
    logic [ADDR_W-1:0]        sram_addr_o;
    logic [DATA_W-1:0]        sram_wr_data_o;
    logic [c_cnt_w-1:0]       tag_cnt_o;
    logic [1:0]               err_o;

    // Environment view: clients plus SRAM controller
    modport master (
        output cl_rd_en_i, cl_wr_en_i, cl_addr_i, cl_wr_data_i,
        output sram_rdy_i, sram_rd_valid_i, sram_rd_data_i,
        input  cl_rdy_o, cl_rd_valid_o, cl_rd_data_o,
        input  sram_rd_en_o, sram_wr_en_o, sram_addr_o, sram_wr_data_o,
        input  tag_cnt_o, err_o
    );

    // Arbiter view
    modport slave (
        input  cl_rd_en_i, cl_wr_en_i, cl_addr_i, cl_wr_data_i,
        input  sram_rdy_i, sram_rd_valid_i, sram_rd_data_i,
        output cl_rdy_o, cl_rd_valid_o, cl_rd_data_o,
        output sram_rd_en_o, sram_wr_en_o, sram_addr_o, sram_wr_data_o,
        output tag_cnt_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/syn_sram_acc_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : syn_sram_acc_arb                                                 |
// | Brief   : NUM_CH-client SRAM access arbiter with read-tag order FIFO       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module syn_sram_acc_arb #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int TAG_DEPTH = 8,
    parameter int MODE      = 1
) (
    input  wire logic          clk_ir,
    input  wire logic          rst_il,
    syn_sram_acc_arb_if.slave  bus
);
    localparam int c_ptr_w = $clog2(NUM_CH);
    localparam int c_tag_aw = $clog2(TAG_DEPTH);
    localparam int c_cnt_w = $clog2(TAG_DEPTH) + 1;

    logic [NUM_CH-1:0]  w_req;
    logic               w_any;
    logic [c_ptr_w-1:0] w_win;
    logic               w_win_rd;
    logic               w_win_wr;
    logic               w_rd_go;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_full;
    logic               w_pop;
    logic               w_accept;
    logic               w_push;
    logic [c_ptr_w-1:0] w_head;

    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_ptr_w-1:0]  r_tag_mem [TAG_DEPTH];
    logic [c_tag_aw-1:0] r_wr_ptr;
    logic [c_tag_aw-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_err;

    assign w_req = bus.cl_rd_en_i | bus.cl_wr_en_i;
    assign w_any = |w_req;

    // Descending scan so the highest-priority requester is the last to assign
    generate
        if (MODE == 0) begin : g_fixed
            always_comb begin
                w_win = '0;
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (w_req[k]) w_win = c_ptr_w'(k);
                end
            end
        end else begin : g_rr
            always_comb begin
                w_win = r_rr_ptr;
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (w_req[(int'(r_rr_ptr) + k) % NUM_CH])
                        w_win = c_ptr_w'((int'(r_rr_ptr) + k) % NUM_CH);
                end
            end
        end
    endgenerate

    always_comb begin
        w_addr   = '0;
        w_wdata  = '0;
        w_win_rd = 1'b0;
        w_win_wr = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == c_ptr_w'(i)) begin
                w_addr   = bus.cl_addr_i[i*ADDR_W +: ADDR_W];
                w_wdata  = bus.cl_wr_data_i[i*DATA_W +: DATA_W];
                w_win_rd = bus.cl_rd_en_i[i];
                w_win_wr = bus.cl_wr_en_i[i];
            end
        end
    end

    // A simultaneous pop frees a slot, so a read may be accepted while full
    assign w_rd_go  = w_win_rd & ~w_win_wr;
    assign w_full   = (r_cnt == c_cnt_w'(TAG_DEPTH));
    assign w_pop    = ~rst_il & bus.sram_rd_valid_i & (r_cnt != '0);
    assign w_accept = ~rst_il & bus.sram_rdy_i & w_any & ~(w_rd_go & w_full & ~w_pop);
    assign w_push   = w_accept & w_rd_go;
    assign w_head   = r_tag_mem[r_rd_ptr];

    assign bus.cl_rdy_o       = w_accept ? (NUM_CH'(1) << w_win) : '0;
    assign bus.cl_rd_valid_o  = w_pop ? (NUM_CH'(1) << w_head) : '0;
    assign bus.cl_rd_data_o   = bus.sram_rd_data_i;
    assign bus.sram_rd_en_o   = w_push;
    assign bus.sram_wr_en_o   = w_accept & w_win_wr;
    assign bus.sram_addr_o    = w_addr;
    assign bus.sram_wr_data_o = w_wdata;
    assign bus.tag_cnt_o      = r_cnt;
    assign bus.err_o          = r_err;

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
        end else begin
            if (w_accept)
                r_rr_ptr <= (w_win == c_ptr_w'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (bus.sram_rd_valid_i && (r_cnt == '0)) r_err[0] <= 1'b1;
            if (w_accept && w_win_rd && w_win_wr)     r_err[1] <= 1'b1;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= w_win;
    end
endmodule
`default_nettype wire

// File: tb/tb_syn_sram_acc_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_syn_sram_acc_arb                                              |
// | Brief   : Scoreboard bench, unit 0 = fixed priority, unit 1 = round-robin   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_syn_sram_acc_arb;
    localparam int NUM_CH = 4, DATA_W = 16, ADDR_W = 18, TAG_DEPTH = 8;

    logic clk_ir = 1'b0;
    logic rst_il = 1'b1;
    always #5 clk_ir = ~clk_ir;

    // Pins, updated only at the falling edge
    logic [NUM_CH-1:0]        p_rd [2], p_wr [2];
    logic [NUM_CH*ADDR_W-1:0] p_addr [2];
    logic [NUM_CH*DATA_W-1:0] p_wdat [2];
    logic                     p_srdy [2], p_srv [2];
    logic [DATA_W-1:0]        p_srd [2];
    logic [NUM_CH-1:0]        o_rdy [2], o_rdv [2];
    logic [DATA_W-1:0]        o_rdata [2], o_wdata [2];
    logic                     o_rden [2], o_wren [2];
    logic [ADDR_W-1:0]        o_addr [2];
    logic [3:0]               o_cnt [2];
    logic [1:0]               o_err [2];

    syn_sram_acc_arb_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                          .TAG_DEPTH(TAG_DEPTH)) bus [2] ();

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            assign bus[g].cl_rd_en_i      = p_rd[g];
            assign bus[g].cl_wr_en_i      = p_wr[g];
            assign bus[g].cl_addr_i       = p_addr[g];
            assign bus[g].cl_wr_data_i    = p_wdat[g];
            assign bus[g].sram_rdy_i      = p_srdy[g];
            assign bus[g].sram_rd_valid_i = p_srv[g];
            assign bus[g].sram_rd_data_i  = p_srd[g];
            assign o_rdy[g]   = bus[g].cl_rdy_o;
            assign o_rdv[g]   = bus[g].cl_rd_valid_o;
            assign o_rdata[g] = bus[g].cl_rd_data_o;
            assign o_rden[g]  = bus[g].sram_rd_en_o;
            assign o_wren[g]  = bus[g].sram_wr_en_o;
            assign o_addr[g]  = bus[g].sram_addr_o;
            assign o_wdata[g] = bus[g].sram_wr_data_o;
            assign o_cnt[g]   = bus[g].tag_cnt_o;
            assign o_err[g]   = bus[g].err_o;

            syn_sram_acc_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                               .TAG_DEPTH(TAG_DEPTH), .MODE(g)) u_dut (
                .clk_ir (clk_ir),
                .rst_il (rst_il),
                .bus    (bus[g])
            );
        end
    endgenerate

    // Reference model: pending client requests, SRAM stimulus, tag order queue
    bit              m_rst;
    bit              pend_rd [2][NUM_CH], pend_wr [2][NUM_CH];
    logic [ADDR_W-1:0] m_addr [2][NUM_CH];
    logic [DATA_W-1:0] m_data [2][NUM_CH];
    bit              s_rdy [2], s_rv [2];
    logic [DATA_W-1:0] s_rd [2];
    int              rr [2];
    int              tagq [2][$];
    logic [1:0]      m_err [2];

    typedef struct {
        int          u;
        logic [3:0]  rdy, rdv, cnt;
        logic        rden, wren;
        logic [17:0] addr;
        logic [15:0] wdata, rdata;
        logic [1:0]  err;
    } exp_t;
    exp_t expq [$];

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, int u, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s unit%0d: got %h, expected %h at %0t", name, u, act, req, $time);
        end
    endfunction

    task automatic set_req(int u, int ch, bit rd, bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        pend_rd[u][ch] = rd;
        pend_wr[u][ch] = wr;
        m_addr[u][ch]  = a;
        m_data[u][ch]  = d;
    endtask

    // One clock: apply stimulus at the falling edge, predict, advance the model
    task automatic cycle();
        @(negedge clk_ir);
        rst_il = m_rst;
        for (int u = 0; u < 2; u++) begin
            exp_t e;
            int   w;
            bit   any, pop, full, wrd, acc;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                p_rd[u][ch] = pend_rd[u][ch];
                p_wr[u][ch] = pend_wr[u][ch];
                p_addr[u][ch*ADDR_W +: ADDR_W] = m_addr[u][ch];
                p_wdat[u][ch*DATA_W +: DATA_W] = m_data[u][ch];
            end
            p_srdy[u] = s_rdy[u];
            p_srv[u]  = s_rv[u];
            p_srd[u]  = s_rd[u];
            any = 0;
            w   = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                int ch;
                ch = (u == 0) ? k : (rr[u] + k) % NUM_CH;
                if (!any && (pend_rd[u][ch] || pend_wr[u][ch])) begin
                    any = 1;
                    w   = ch;
                end
            end
            pop  = !m_rst && s_rv[u] && tagq[u].size() > 0;
            full = tagq[u].size() == TAG_DEPTH;
            wrd  = pend_rd[u][w] && !pend_wr[u][w];
            acc  = !m_rst && s_rdy[u] && any && !(wrd && full && !pop);
            e.u     = u;
            e.rdy   = acc ? 4'(1 << w) : 4'd0;
            e.rden  = acc && wrd;
            e.wren  = acc && pend_wr[u][w];
            e.addr  = m_addr[u][w];
            e.wdata = m_data[u][w];
            e.rdv   = pop ? 4'(1 << tagq[u][0]) : 4'd0;
            e.rdata = s_rd[u];
            e.cnt   = 4'(tagq[u].size());
            e.err   = m_err[u];
            expq.push_back(e);
            if (m_rst) begin
                tagq[u].delete();
                rr[u]    = 0;
                m_err[u] = 2'b00;
            end else begin
                if (s_rv[u] && tagq[u].size() == 0) m_err[u][0] = 1'b1;
                if (pop) void'(tagq[u].pop_front());
                if (acc && wrd) tagq[u].push_back(w);
                if (acc && pend_rd[u][w] && pend_wr[u][w]) m_err[u][1] = 1'b1;
                if (acc) begin
                    rr[u] = (w + 1) % NUM_CH;
                    pend_rd[u][w] = 0;
                    pend_wr[u][w] = 0;
                end
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            bit busy;
            busy = 0;
            for (int u = 0; u < 2; u++) begin
                s_rdy[u] = 1;
                s_rv[u]  = tagq[u].size() > 0;
                s_rd[u]  = DATA_W'($urandom);
                if (tagq[u].size() > 0) busy = 1;
                for (int ch = 0; ch < NUM_CH; ch++)
                    if (pend_rd[u][ch] || pend_wr[u][ch]) busy = 1;
            end
            if (!busy) break;
            cycle();
        end
        for (int u = 0; u < 2; u++) s_rv[u] = 0;
    endtask

    // Monitor: compares every DUT output against the predicted record
    initial begin
        forever begin
            @(negedge clk_ir);
            #2;
            while (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("cl_rdy", e.u, 32'(o_rdy[e.u]), 32'(e.rdy));
                chk("sram_rd_en", e.u, 32'(o_rden[e.u]), 32'(e.rden));
                chk("sram_wr_en", e.u, 32'(o_wren[e.u]), 32'(e.wren));
                chk("cl_rd_valid", e.u, 32'(o_rdv[e.u]), 32'(e.rdv));
                chk("tag_cnt", e.u, 32'(o_cnt[e.u]), 32'(e.cnt));
                chk("err", e.u, 32'(o_err[e.u]), 32'(e.err));
                if (e.rden || e.wren) chk("sram_addr", e.u, 32'(o_addr[e.u]), 32'(e.addr));
                if (e.wren) chk("sram_wr_data", e.u, 32'(o_wdata[e.u]), 32'(e.wdata));
                if (e.rdv != 0) chk("cl_rd_data", e.u, 32'(o_rdata[e.u]), 32'(e.rdata));
            end
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int ch = 0; ch < NUM_CH; ch++) set_req(u, ch, 0, 0, '0, '0);
            s_rdy[u] = 0; s_rv[u] = 0; s_rd[u] = '0; rr[u] = 0; m_err[u] = 2'b00;
        end
        m_rst = 1;
        repeat (3) cycle();
        m_rst = 0;

        // Round-robin rotation with all four clients writing
        for (int n = 0; n < 5; n++) begin
            for (int u = 0; u < 2; u++) begin
                s_rdy[u] = 1;
                for (int ch = 0; ch < NUM_CH; ch++)
                    if (!pend_wr[u][ch]) set_req(u, ch, 0, 1, ADDR_W'(ch * 16 + n), DATA_W'($urandom));
            end
            cycle();
            #3 chk("rr_rotation", 1, 32'(o_rdy[1]), 32'(1 << (n % 4)));
        end
        drain();

        // Fixed priority: ch1 holds off ch3
        s_rdy[0] = 0;
        set_req(0, 1, 0, 1, 18'h00111, 16'h1111);
        set_req(0, 3, 0, 1, 18'h00333, 16'h3333);
        repeat (2) cycle();
        s_rdy[0] = 1;
        for (int n = 0; n < 3; n++) begin
            if (!pend_wr[0][1]) set_req(0, 1, 0, 1, 18'h00111, DATA_W'(n));
            cycle();
            #3 chk("prio_ch1", 0, 32'(o_rdy[0]), 32'h2);
        end
        cycle();
        #3 chk("prio_ch3", 0, 32'(o_rdy[0]), 32'h8);
        drain();

        // Reads return to the issuing channel in order
        for (int u = 0; u < 2; u++) begin s_rdy[u] = 1; set_req(u, 2, 1, 0, 18'h00010, '0); end
        cycle();
        for (int u = 0; u < 2; u++) set_req(u, 0, 1, 0, 18'h3FFFF, '0);
        cycle();
        for (int u = 0; u < 2; u++) begin s_rv[u] = 1; s_rd[u] = 16'hA5A5; end
        cycle();
        #3 for (int u = 0; u < 2; u++) begin
            chk("rd_ret_ch2", u, 32'(o_rdv[u]), 32'h4);
            chk("rd_ret_data0", u, 32'(o_rdata[u]), 32'hA5A5);
        end
        for (int u = 0; u < 2; u++) s_rd[u] = 16'h5A5A;
        cycle();
        #3 for (int u = 0; u < 2; u++) begin
            chk("rd_ret_ch0", u, 32'(o_rdv[u]), 32'h1);
            chk("rd_ret_data1", u, 32'(o_rdata[u]), 32'h5A5A);
        end
        for (int u = 0; u < 2; u++) s_rv[u] = 0;
        drain();

        // Fill the tag FIFO on unit 0
        for (int n = 0; n < 30 && tagq[0].size() < TAG_DEPTH; n++) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                if (!pend_rd[0][ch]) set_req(0, ch, 1, 0, ADDR_W'($urandom), '0);
            cycle();
        end
        for (int ch = 0; ch < NUM_CH; ch++) set_req(0, ch, 0, 0, '0, '0);
        set_req(0, 2, 1, 0, 18'h02222, '0);
        cycle();
        #3 chk("full_cnt", 0, 32'(o_cnt[0]), 32'd8);
        chk("full_block", 0, 32'(o_rdy[0]), 32'h0);
        set_req(0, 1, 0, 1, 18'h01111, 16'hBEEF);
        cycle();
        #3 chk("full_write", 0, 32'(o_rdy[0]), 32'h2);
        s_rv[0] = 1; s_rd[0] = 16'h1234;
        cycle();
        #3 chk("full_pushpop", 0, 32'(o_rdy[0]), 32'h4);
        s_rv[0] = 0;
        cycle();
        #3 chk("full_cnt_hold", 0, 32'(o_cnt[0]), 32'd8);

        // Return with nothing outstanding on unit 1
        s_rv[1] = 1; s_rd[1] = 16'hDEAD;
        cycle();
        #3 chk("orphan_valid", 1, 32'(o_rdv[1]), 32'h0);
        s_rv[1] = 0;
        cycle();
        #3 chk("orphan_err", 1, 32'(o_err[1]), 32'h1);

        // Reset with reads outstanding
        for (int ch = 0; ch < 3; ch++) begin
            set_req(1, ch, 1, 0, ADDR_W'(ch), '0);
            cycle();
        end
        for (int ch = 0; ch < NUM_CH; ch++) set_req(1, ch, 0, 1, ADDR_W'(ch), DATA_W'(ch));
        m_rst = 1;
        repeat (2) cycle();
        #3 chk("rst_cnt", 1, 32'(o_cnt[1]), 32'd0);
        chk("rst_err", 1, 32'(o_err[1]), 32'd0);
        chk("rst_rdy", 1, 32'(o_rdy[1]), 32'd0);
        m_rst = 0;
        cycle();
        #3 chk("rst_rr_ch0", 1, 32'(o_rdy[1]), 32'h1);
        drain();

        // Randomised traffic
        for (int n = 0; n < 2500; n++) begin
            for (int u = 0; u < 2; u++) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (!pend_rd[u][ch] && !pend_wr[u][ch] && $urandom_range(2) == 0) begin
                        int t;
                        t = $urandom_range(15);
                        set_req(u, ch, t < 8 || t == 15, t >= 8, ADDR_W'($urandom), DATA_W'($urandom));
                    end
                end
                s_rdy[u] = $urandom_range(3) != 0;
                s_rv[u]  = (tagq[u].size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(40) == 0);
                s_rd[u]  = DATA_W'($urandom);
            end
            cycle();
        end
        drain();
        repeat (2) cycle();
        #3 chk("scoreboard_empty", 0, 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
